// File: rtl/id_pkg.sv
// Shared decode definitions for the instruction-decode stage.
// Holds the MIPS opcode/funct values, the ex_ctrl bit positions, the five
// control-word encodings, and small helpers used by id_stage, id_regfile and
// id_stage_if.
package id_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_BEQ   = 6'h04,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam int CTRL_W = 10;
  typedef logic [CTRL_W-1:0] ctrl_t;

  localparam int CTRL_REGWRITE = 9;
  localparam int CTRL_MEMTOREG = 8;
  localparam int CTRL_MEMREAD  = 7;
  localparam int CTRL_MEMWRITE = 6;
  localparam int CTRL_BRANCH   = 5;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_REGDST   = 3;
  localparam int CTRL_ALUOP_LO = 0;

  localparam ctrl_t CTRL_RTYPE = 10'b1000001010;
  localparam ctrl_t CTRL_LW    = 10'b1110010000;
  localparam ctrl_t CTRL_SW    = 10'b0001010000;
  localparam ctrl_t CTRL_BEQ   = 10'b0000100001;
  localparam ctrl_t CTRL_ADDI  = 10'b1000010000;

  // Register-address width derived from the register count.
  function automatic int rw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Unknown opcodes decode to an all-zero control word (a harmless no-op).
  function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
    ctrl_t c;
    case (opcode)
      OP_RTYPE: c = CTRL_RTYPE;
      OP_LW:    c = CTRL_LW;
      OP_SW:    c = CTRL_SW;
      OP_BEQ:   c = CTRL_BEQ;
      OP_ADDI:  c = CTRL_ADDI;
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Bundle of all non-clock signals of the decode stage.
//   master : environment side (drives IF/ID slot, flush, ex_ready, write-back)
//   slave  : id_stage side (drives id_stall and the ID/EX register outputs)
interface id_stage_if
  import id_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int RW = rw_of(NREGS);

  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instr;
  logic            flush;
  logic            ex_ready;
  logic            wb_en;
  logic [RW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;

  logic            id_stall;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs_val;
  logic [XLEN-1:0] ex_rt_val;
  logic [XLEN-1:0] ex_imm;
  logic [RW-1:0]   ex_dest;
  logic [CTRL_W-1:0] ex_ctrl;

  modport master (
    output if_valid, if_pc, if_instr, flush, ex_ready, wb_en, wb_addr, wb_data,
    input  id_stall, ex_valid, ex_pc, ex_rs_val, ex_rt_val, ex_imm, ex_dest, ex_ctrl
  );

  modport slave (
    input  if_valid, if_pc, if_instr, flush, ex_ready, wb_en, wb_addr, wb_data,
    output id_stall, ex_valid, ex_pc, ex_rs_val, ex_rt_val, ex_imm, ex_dest, ex_ctrl
  );
endinterface

// File: rtl/id_regfile.sv
// NREGS x XLEN register file: one synchronous write port, two combinational
// read ports with write-through bypass. Register 0 always reads zero and
// ignores writes. Asynchronous active-low reset clears every register.
//   clk, rst_n        : clock / async reset
//   wb_en/addr/data   : write port
//   ra_addr/ra_data   : read port A
//   rb_addr/rb_data   : read port B
module id_regfile
  import id_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wb_en,
  input  logic [rw_of(NREGS)-1:0]  wb_addr,
  input  logic [XLEN-1:0]          wb_data,
  input  logic [rw_of(NREGS)-1:0]  ra_addr,
  output logic [XLEN-1:0]          ra_data,
  input  logic [rw_of(NREGS)-1:0]  rb_addr,
  output logic [XLEN-1:0]          rb_data
);
  localparam int RW = rw_of(NREGS);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (wb_en && (wb_addr != '0) && (int'(wb_addr) < NREGS)) begin
      regs_d[wb_addr] = wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Same-cycle write-back is forwarded so decode never sees a stale value.
  function automatic logic [XLEN-1:0] rd_port(input logic [RW-1:0] addr);
    if (addr == '0) begin
      return '0;
    end else if (wb_en && (wb_addr == addr)) begin
      return wb_data;
    end else begin
      return regs_q[addr];
    end
  endfunction

  always_comb begin
    ra_data = rd_port(ra_addr);
    rb_data = rd_port(rb_addr);
  end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage with ID/EX pipeline register.
// Decodes the IF/ID slot, reads operands from id_regfile, detects load-use
// hazards against the instruction in ID/EX, and honours EX backpressure
// and flush.
//   clk, rst_n : clock / async active-low reset
//   bus        : id_stage_if.slave (IF/ID slot, flush, ex_ready, write-back
//                in; id_stall and ID/EX fields out)
module id_stage
  import id_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  id_stage_if.slave   bus
);
  localparam int RW = rw_of(NREGS);

  logic [5:0]      opcode;
  logic [RW-1:0]   rs_addr;
  logic [RW-1:0]   rt_addr;
  logic [RW-1:0]   rd_addr;
  logic [15:0]     imm;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  ctrl_t           ctrl_dec;
  logic [RW-1:0]   dest_dec;
  logic            hazard;

  logic            ex_valid_q,  ex_valid_d;
  logic [XLEN-1:0] ex_pc_q,     ex_pc_d;
  logic [XLEN-1:0] ex_rs_val_q, ex_rs_val_d;
  logic [XLEN-1:0] ex_rt_val_q, ex_rt_val_d;
  logic [XLEN-1:0] ex_imm_q,    ex_imm_d;
  logic [RW-1:0]   ex_dest_q,   ex_dest_d;
  ctrl_t           ex_ctrl_q,   ex_ctrl_d;

  always_comb begin
    opcode   = bus.if_instr[31:26];
    rs_addr  = RW'(bus.if_instr[25:21]);
    rt_addr  = RW'(bus.if_instr[20:16]);
    rd_addr  = RW'(bus.if_instr[15:11]);
    imm      = bus.if_instr[15:0];
    imm_ext  = {{(XLEN-16){imm[15]}}, imm};
    ctrl_dec = decode_ctrl(opcode);
    dest_dec = ctrl_dec[CTRL_REGDST] ? rd_addr : rt_addr;
  end

  id_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .wb_en   (bus.wb_en),
    .wb_addr (bus.wb_addr),
    .wb_data (bus.wb_data),
    .ra_addr (rs_addr),
    .ra_data (rs_val),
    .rb_addr (rt_addr),
    .rb_data (rt_val)
  );

  // Load in ID/EX whose destination is a source of the instruction in decode.
  always_comb begin
    hazard = ex_valid_q && ex_ctrl_q[CTRL_MEMREAD] && (ex_dest_q != '0) &&
             bus.if_valid && ((ex_dest_q == rs_addr) || (ex_dest_q == rt_addr));
  end

  // Priority: backpressure holds everything, then flush, then hazard bubble.
  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_pc_d     = ex_pc_q;
    ex_rs_val_d = ex_rs_val_q;
    ex_rt_val_d = ex_rt_val_q;
    ex_imm_d    = ex_imm_q;
    ex_dest_d   = ex_dest_q;
    ex_ctrl_d   = ex_ctrl_q;
    if (bus.ex_ready) begin
      if (bus.flush || hazard) begin
        ex_valid_d = 1'b0;
      end else begin
        ex_valid_d  = bus.if_valid;
        ex_pc_d     = bus.if_pc;
        ex_rs_val_d = rs_val;
        ex_rt_val_d = rt_val;
        ex_imm_d    = imm_ext;
        ex_dest_d   = dest_dec;
        ex_ctrl_d   = ctrl_dec;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_pc_q     <= '0;
      ex_rs_val_q <= '0;
      ex_rt_val_q <= '0;
      ex_imm_q    <= '0;
      ex_dest_q   <= '0;
      ex_ctrl_q   <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_pc_q     <= ex_pc_d;
      ex_rs_val_q <= ex_rs_val_d;
      ex_rt_val_q <= ex_rt_val_d;
      ex_imm_q    <= ex_imm_d;
      ex_dest_q   <= ex_dest_d;
      ex_ctrl_q   <= ex_ctrl_d;
    end
  end

  // A flushed instruction is discarded, so IF may advance past it.
  assign bus.id_stall  = !bus.flush && (!bus.ex_ready || hazard);
  assign bus.ex_valid  = ex_valid_q;
  assign bus.ex_pc     = ex_pc_q;
  assign bus.ex_rs_val = ex_rs_val_q;
  assign bus.ex_rt_val = ex_rt_val_q;
  assign bus.ex_imm    = ex_imm_q;
  assign bus.ex_dest   = ex_dest_q;
  assign bus.ex_ctrl   = ex_ctrl_q;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios followed by random
// traffic, all compared against a behavioural pipeline/register model.
module tb_id_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_stage_if #(.XLEN(32), .NREGS(32)) bus ();

  id_stage #(.XLEN(32), .NREGS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] mregs [32];
  logic        m_valid;
  logic        m_known;
  logic [31:0] m_pc, m_rs, m_rt, m_imm;
  int          m_dest;
  logic [9:0]  m_ctrl;
  logic        last_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Control word built from what each instruction class does.
  function automatic logic [9:0] ref_ctrl(input logic [5:0] op);
    bit is_r, is_lw, is_sw, is_beq, is_addi;
    bit reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst;
    logic [2:0] alu_op;
    is_r    = (op == 6'd0);
    is_lw   = (op == 6'd35);
    is_sw   = (op == 6'd43);
    is_beq  = (op == 6'd4);
    is_addi = (op == 6'd8);
    reg_write  = is_r || is_lw || is_addi;
    mem_to_reg = is_lw;
    mem_read   = is_lw;
    mem_write  = is_sw;
    branch     = is_beq;
    alu_src    = is_lw || is_sw || is_addi;
    reg_dst    = is_r;
    alu_op     = is_r ? 3'd2 : (is_beq ? 3'd1 : 3'd0);
    return {reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst, alu_op};
  endfunction

  function automatic logic [31:0] ref_read(input int a);
    if (a == 0) return 32'h0;
    if (bus.wb_en && int'(bus.wb_addr) == a) return bus.wb_data;
    return mregs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    m_valid = 1'b0; m_known = 1'b1;
    m_pc = 0; m_rs = 0; m_rt = 0; m_imm = 0; m_dest = 0; m_ctrl = 0;
    last_stall = 1'b0;
  endtask

  task automatic check_outputs(input string pfx);
    chk({pfx, "_ex_valid"}, bus.ex_valid, m_valid);
    if (m_known) begin
      chk({pfx, "_ex_pc"},   bus.ex_pc,     m_pc);
      chk({pfx, "_ex_rs"},   bus.ex_rs_val, m_rs);
      chk({pfx, "_ex_rt"},   bus.ex_rt_val, m_rt);
      chk({pfx, "_ex_imm"},  bus.ex_imm,    m_imm);
      chk({pfx, "_ex_dest"}, bus.ex_dest,   m_dest);
      chk({pfx, "_ex_ctrl"}, bus.ex_ctrl,   m_ctrl);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic fl, input logic rdy, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
    bus.if_valid = v;  bus.if_pc = pc;  bus.if_instr = instr;
    bus.flush = fl;    bus.ex_ready = rdy;
    bus.wb_en = we;    bus.wb_addr = wa; bus.wb_data = wd;
  endtask

  // One clock: check stall before the edge, advance model, check ID/EX after.
  task automatic step();
    int rs, rt, rd;
    logic haz, exp_stall;
    logic [9:0] c;
    logic        n_valid, n_known;
    logic [31:0] n_pc, n_rs, n_rt, n_imm;
    int          n_dest;
    logic [9:0]  n_ctrl;
    #1;
    rs = int'(bus.if_instr[25:21]);
    rt = int'(bus.if_instr[20:16]);
    rd = int'(bus.if_instr[15:11]);
    haz = m_valid && m_ctrl[7] && (m_dest != 0) && bus.if_valid &&
          ((m_dest == rs) || (m_dest == rt));
    exp_stall = !bus.flush && (!bus.ex_ready || haz);
    chk("id_stall", bus.id_stall, exp_stall);
    last_stall = exp_stall;
    n_valid = m_valid; n_known = m_known; n_pc = m_pc; n_rs = m_rs; n_rt = m_rt;
    n_imm = m_imm; n_dest = m_dest; n_ctrl = m_ctrl;
    if (bus.ex_ready) begin
      if (bus.flush || haz) begin
        n_valid = 1'b0; n_known = 1'b0;
      end else begin
        c = ref_ctrl(bus.if_instr[31:26]);
        n_valid = bus.if_valid; n_known = 1'b1;
        n_pc = bus.if_pc;
        n_rs = ref_read(rs);
        n_rt = ref_read(rt);
        n_imm = 32'(signed'(bus.if_instr[15:0]));
        n_ctrl = c;
        n_dest = c[3] ? rd : rt;
      end
    end
    @(posedge clk);
    if (bus.wb_en && bus.wb_addr != 5'd0) mregs[bus.wb_addr] = bus.wb_data;
    m_valid = n_valid; m_known = n_known; m_pc = n_pc; m_rs = n_rs; m_rt = n_rt;
    m_imm = n_imm; m_dest = n_dest; m_ctrl = n_ctrl;
    #1;
    check_outputs("step");
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_valid"}, bus.ex_valid, 0);
    chk({pfx, "_pc"},    bus.ex_pc, 0);
    chk({pfx, "_rs"},    bus.ex_rs_val, 0);
    chk({pfx, "_rt"},    bus.ex_rt_val, 0);
    chk({pfx, "_imm"},   bus.ex_imm, 0);
    chk({pfx, "_dest"},  bus.ex_dest, 0);
    chk({pfx, "_ctrl"},  bus.ex_ctrl, 0);
    chk({pfx, "_stall"}, bus.id_stall, 0);
  endtask

  initial begin
    logic [31:0] instr, pc;
    logic [5:0] ops [6];
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B;
    ops[3] = 6'h04; ops[4] = 6'h08; ops[5] = 6'h0D;

    model_reset();
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Preload r[i] = i
    for (int i = 1; i < 32; i++) begin
      drive(0, 0, 0, 0, 1, 1, 5'(i), 32'(i));
      step();
    end

    // add r8, r4, r6
    drive(1, 32'h100, 32'h00864020, 0, 1, 0, 0, 0);
    step();
    chk("add_rs", bus.ex_rs_val, 4);
    chk("add_rt", bus.ex_rt_val, 6);
    chk("add_dest", bus.ex_dest, 8);
    chk("add_ctrl", bus.ex_ctrl, 10'b1000001010);
    chk("add_valid", bus.ex_valid, 1);

    // lw r5 then dependent add: one stall, one bubble
    drive(1, 32'h104, 32'h8C250000, 0, 1, 0, 0, 0);
    step();
    chk("lw_ctrl", bus.ex_ctrl, 10'b1110010000);
    drive(1, 32'h108, 32'h00A64020, 0, 1, 0, 0, 0);
    #1 chk("lu_stall", bus.id_stall, 1);
    step();
    chk("lu_bubble", bus.ex_valid, 0);
    step();
    chk("lu_after_stall", bus.id_stall, 0);
    chk("lu_add_valid", bus.ex_valid, 1);
    chk("lu_add_rs", bus.ex_rs_val, 5);

    // Write-through bypass, then r0 write ignored
    drive(1, 32'h10C, 32'h00864020, 0, 1, 1, 5'd4, 32'hDEAD);
    step();
    chk("bypass_rs", bus.ex_rs_val, 32'hDEAD);
    drive(0, 32'h110, 32'h0, 0, 1, 1, 5'd0, 32'd5);
    step();
    drive(1, 32'h114, 32'h00064020, 0, 1, 0, 0, 0);
    step();
    chk("r0_read", bus.ex_rs_val, 0);

    // addi r2, r1, -1
    drive(1, 32'h118, 32'h2022FFFF, 0, 1, 0, 0, 0);
    step();
    chk("addi_imm", bus.ex_imm, 32'hFFFFFFFF);
    chk("addi_dest", bus.ex_dest, 2);
    chk("addi_ctrl", bus.ex_ctrl, 10'b1000010000);

    // Backpressure for 3 cycles with changing inputs
    for (int i = 0; i < 3; i++) begin
      drive(1, $urandom, $urandom, 0, 0, 0, 0, 0);
      step();
      chk("bp_hold_imm", bus.ex_imm, 32'hFFFFFFFF);
      chk("bp_hold_dest", bus.ex_dest, 2);
    end
    // Flush
    drive(1, 32'h11C, 32'h00864020, 1, 1, 0, 0, 0);
    #1 chk("flush_stall", bus.id_stall, 0);
    step();
    chk("flush_valid", bus.ex_valid, 0);

    // Reset in the middle of a load-use stall with a pending write
    drive(1, 32'h120, 32'h8C250000, 0, 1, 0, 0, 0);
    step();
    drive(1, 32'h124, 32'h00A64020, 0, 1, 1, 5'd4, 32'h1234);
    #1 chk("rst_pre_stall", bus.id_stall, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    drive(1, 32'h200, 32'h00864020, 0, 1, 0, 0, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_rs", bus.ex_rs_val, 0);
    chk("post_rst_valid", bus.ex_valid, 1);

    // Random traffic; IF holds its slot while stalled
    pc = 32'h1000; instr = 32'h0;
    for (int i = 0; i < 400; i++) begin
      if (!last_stall) begin
        pc = pc + 4;
        instr = {ops[$urandom_range(0, 5)], 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 11'($urandom)};
      end
      drive(($urandom_range(0, 9) != 0), pc, instr,
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 4) != 0),
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath and register width.
REQ-002 Parameter NREGS, default 32, register count; RW = ceil(log2(NREGS)) is derived, not overridable.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 if_valid  input  1  IF/ID slot holds an instruction.
REQ-006 if_pc  input  XLEN  instruction address; if_instr  input  32  MIPS-format instruction.
REQ-007 flush  input  1  discard the instruction being decoded.
REQ-008 ex_ready  input  1  EX stage accepts ID/EX contents this cycle.
REQ-009 wb_en  input  1, wb_addr  input  RW, wb_data  input  XLEN  register write-back port.
REQ-010 id_stall  output  1  IF shall hold if_pc/if_instr.
REQ-011 ex_valid  output  1; ex_pc, ex_rs_val, ex_rt_val, ex_imm  output  XLEN each; ex_dest  output  RW; ex_ctrl  output  10  registered ID/EX fields.

Function
REQ-012 Fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0], imm [15:0]; ex_imm is imm sign-extended to XLEN.
REQ-013 ex_ctrl order: [9]RegWrite [8]MemToReg [7]MemRead [6]MemWrite [5]Branch [4]ALUSrc [3]RegDst [2:0]ALUOp.
REQ-014 Encodings: R-type (opcode 0x00) 10'b1000001010; lw (0x23) 10'b1110010000; sw (0x2B) 10'b0001010000; beq (0x04) 10'b0000100001; addi (0x08) 10'b1000010000; any other opcode 0 with ex_valid still following REQ-017.
REQ-015 ex_dest = rd when RegDst=1, else rt.
REQ-016 Register file NREGS x XLEN, one synchronous write port, two combinational read ports; register 0 reads 0, writes to it ignored.
REQ-017 Latency one cycle: on a rising edge with ex_ready=1, no hazard, no flush, ID/EX loads decoded fields and ex_valid <= if_valid.
REQ-018 Write-through bypass: wb_en=1 with wb_addr equal to nonzero rs/rt returns wb_data on that read in the same cycle.
REQ-019 Load-use hazard: ex_valid=1, ex_ctrl[7]=1, ex_dest nonzero and equal to rs or rt of a valid instruction -> id_stall=1 combinationally; next edge (ex_ready=1) ex_valid <= 0 (bubble); instruction issued the following cycle.
REQ-020 Backpressure: ex_ready=0 -> all ID/EX outputs hold, id_stall=1; takes precedence over hazard bubble insertion.
REQ-021 Flush: flush=1 at an edge with ex_ready=1 -> ex_valid <= 0, other fields don't-care; flush wins over hazard; id_stall=0 while flush=1.
REQ-022 Register writes occur regardless of stall, flush or ex_ready.

Reset
REQ-023 rst_n low clears immediately: ex_valid, ex_pc, ex_rs_val, ex_rt_val, ex_imm, ex_dest, ex_ctrl to 0 and every register to 0; id_stall derives from these (0).
REQ-024 Reset mid-stall discards the stalled instruction and any pending write; first post-reset edge behaves as REQ-017.

Structure
REQ-025 Shared package id_pkg holds opcode/funct constants, ex_ctrl bit positions and the five control encodings.
REQ-026 Register file is sub-module id_regfile (parameters XLEN, NREGS; bypass inside it).

Verification
REQ-027 Preload ri=i via wb port; if_instr 0x00864020 (add r8,r4,r6) -> next edge ex_rs_val=4, ex_rt_val=6, ex_dest=8, ex_ctrl=10'b1000001010, ex_valid=1.
REQ-028 lw 0x8C250000 then add 0x00A64020 -> id_stall=1 one cycle, one bubble (ex_valid=0), then add with ex_rs_val=5.
REQ-029 wb_en=1, wb_addr=4, wb_data=0xDEAD in decode cycle of 0x00864020 -> ex_rs_val=0xDEAD; wb r0=5 then read r0 -> 0.
REQ-030 addi 0x2022FFFF -> ex_imm=0xFFFFFFFF, ex_dest=2, ex_ctrl=10'b1000010000.
REQ-031 ex_ready=0 for 3 cycles -> outputs constant, id_stall=1; flush with ex_ready=1 -> ex_valid=0 next edge.
REQ-032 rst_n low mid-stall -> all outputs 0 before next edge; registers read 0.
